// File: rtl/rv_lsu_wb.sv
// Memory/writeback stage: registers the ALU-stage result, runs the data-bus access with a
// timeout, aligns load data and presents one registered writeback per instruction.
module rv_lsu_wb #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_load,
  input  logic        i_store,
  input  logic        i_reg_write,
  input  logic [4:0]  i_rd,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wsel,
  output logic        o_stall,
  output logic        o_dbus_req,
  output logic        o_dbus_we,
  output logic [31:0] o_dbus_addr,
  output logic [31:0] o_dbus_wdata,
  output logic [3:0]  o_dbus_sel,
  input  logic        i_dbus_ack,
  input  logic [31:0] i_dbus_rdata,
  output logic        o_wb_write,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_misalign,
  output logic        o_bus_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUS} state_t;

  state_t        state;
  logic [CW-1:0] count;

  logic          valid;
  logic          load;
  logic          store;
  logic          reg_write;
  logic [4:0]    rd;
  logic [2:0]    funct3;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [3:0]    wsel;

  logic          mem_op;
  logic          misaligned;
  logic          bad_align;
  logic          issue;
  logic          timeout_hit;
  logic          complete;
  logic          error;
  logic          wb_en;
  logic [7:0]    lane_byte;
  logic [15:0]   lane_half;
  logic [31:0]   load_data;
  logic [31:0]   wb_value;

  // The captured instruction is held while stalled, so the bus fields stay stable in BUS.
  always_comb begin
    mem_op      = load | store;
    misaligned  = ((funct3[1:0] == 2'b01) && addr[0]) ||
                  ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    bad_align   = valid && mem_op && misaligned;
    issue       = valid && mem_op && !misaligned;
    timeout_hit = (state == BUS) && (count == LAST_COUNT) && !i_dbus_ack;
    complete    = valid && (!mem_op || misaligned || i_dbus_ack || timeout_hit);
    error       = bad_align || timeout_hit;
    wb_en       = complete && !error && reg_write && (rd != 5'd0) && !store;
  end

  assign o_stall      = issue && !i_dbus_ack && !timeout_hit;
  assign o_dbus_req   = issue;
  assign o_dbus_we    = issue && store;
  assign o_dbus_addr  = issue ? {addr[31:2], 2'b00} : 32'h0;
  assign o_dbus_wdata = issue ? wdata : 32'h0;
  assign o_dbus_sel   = issue ? (store ? wsel : 4'b1111) : 4'b0000;

  always_comb begin
    case (addr[1:0])
      2'b00:   lane_byte = i_dbus_rdata[7:0];
      2'b01:   lane_byte = i_dbus_rdata[15:8];
      2'b10:   lane_byte = i_dbus_rdata[23:16];
      default: lane_byte = i_dbus_rdata[31:24];
    endcase
    lane_half = addr[1] ? i_dbus_rdata[31:16] : i_dbus_rdata[15:0];
    case (funct3)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_data = {24'h0, lane_byte};
      3'b101:  load_data = {16'h0, lane_half};
      default: load_data = i_dbus_rdata;
    endcase
    wb_value = load ? load_data : addr;
  end

  // The counter tallies request cycles, so the issuing IDLE cycle is already the first one
  // and the request stays up for exactly TIMEOUT_CYCLES cycles before an abort.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      count      <= '0;
      valid      <= 1'b0;
      load       <= 1'b0;
      store      <= 1'b0;
      reg_write  <= 1'b0;
      rd         <= 5'd0;
      funct3     <= 3'd0;
      addr       <= 32'h0;
      wdata      <= 32'h0;
      wsel       <= 4'h0;
      o_wb_write <= 1'b0;
      o_wb_rd    <= 5'd0;
      o_wb_data  <= 32'h0;
      o_misalign <= 1'b0;
      o_bus_err  <= 1'b0;
    end else begin
      if (!o_stall) begin
        valid     <= 1'b1;
        load      <= i_load;
        store     <= i_store;
        reg_write <= i_reg_write;
        rd        <= i_rd;
        funct3    <= i_funct3;
        addr      <= i_alu_result;
        wdata     <= i_wdata;
        wsel      <= i_wsel;
      end
      case (state)
        IDLE: begin
          if (issue && !i_dbus_ack) begin
            state <= BUS;
            count <= CW'(1);
          end
        end
        BUS: begin
          if (i_dbus_ack || timeout_hit) begin
            state <= IDLE;
            count <= '0;
          end else if (count != '1) begin
            count <= count + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
      o_misalign <= bad_align;
      o_bus_err  <= timeout_hit;
      o_wb_write <= wb_en;
      if (wb_en) begin
        o_wb_rd   <= rd;
        o_wb_data <= wb_value;
      end
    end
  end

endmodule

// File: tb/tb_rv_lsu_wb.sv
// Self-checking bench for rv_lsu_wb: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a transaction-level model.
module tb_rv_lsu_wb;

  localparam int T = 8;

  logic        clk;
  logic        reset_n;
  logic        load;
  logic        store;
  logic        reg_write;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] wdata;
  logic [3:0]  wsel;
  logic        stall;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_sel;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        wb_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;
  logic        bus_err;

  int n_vec = 0;
  int n_err = 0;

  rv_lsu_wb #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_load       (load),
    .i_store      (store),
    .i_reg_write  (reg_write),
    .i_rd         (rd),
    .i_funct3     (funct3),
    .i_alu_result (alu_result),
    .i_wdata      (wdata),
    .i_wsel       (wsel),
    .o_stall      (stall),
    .o_dbus_req   (dbus_req),
    .o_dbus_we    (dbus_we),
    .o_dbus_addr  (dbus_addr),
    .o_dbus_wdata (dbus_wdata),
    .o_dbus_sel   (dbus_sel),
    .i_dbus_ack   (dbus_ack),
    .i_dbus_rdata (dbus_rdata),
    .o_wb_write   (wb_write),
    .o_wb_rd      (wb_rd),
    .o_wb_data    (wb_data),
    .o_misalign   (misalign),
    .o_bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic ld, input logic st, input logic rw, input logic [4:0] r,
                                input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] ws);
    load       = ld;
    store      = st;
    reg_write  = rw;
    rd         = r;
    funct3     = f3;
    alu_result = a;
    wdata      = wd;
    wsel       = ws;
  endtask

  task automatic bubble();
    apply_stimulus(1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'h0, 32'h0, 4'h0);
  endtask

  // Reference: extract the addressed byte/half from the bus word and extend by width and sign.
  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
    int nbytes;
    logic [31:0] v;
    nbytes = 1 << f3[1:0];
    if (nbytes >= 4) return w;
    v = w >> (8 * int'(a[1:0]));
    if (nbytes == 1) begin
      v = v & 32'h0000_00FF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = v & 32'h0000_FFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Model: one instruction in the stage, how many request cycles it has used, and the
  // registered outputs the next edge must produce.
  bit          model_ok = 1'b0;
  bit          m_valid, m_load, m_store, m_rw;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wsel;
  int          m_wait;
  bit          m_wb_write, m_mis, m_err;
  logic [4:0]  m_wb_rd;
  logic [31:0] m_wb_data;

  always @(negedge clk) begin : model_cmp
    int nbytes;
    bit e_mem, e_mis, e_req, e_timeout, e_stall, e_done, e_bad, e_wb;
    nbytes    = 1 << m_f3[1:0];
    e_mem     = m_load || m_store;
    e_mis     = e_mem && ((m_addr % nbytes) != 0);
    e_req     = m_valid && e_mem && !e_mis;
    e_timeout = e_req && !dbus_ack && (m_wait + 1 == T);
    e_stall   = e_req && !dbus_ack && !e_timeout;
    if (model_ok) begin
      check_output("stall", {31'h0, stall}, {31'h0, e_stall});
      check_output("req", {31'h0, dbus_req}, {31'h0, e_req});
      if (e_req) begin
        check_output("bus_addr", dbus_addr, m_addr & 32'hFFFF_FFFC);
        check_output("bus_we", {31'h0, dbus_we}, {31'h0, m_store});
        check_output("bus_wdata", dbus_wdata, m_wdata);
        check_output("bus_sel", {28'h0, dbus_sel}, {28'h0, (m_store ? m_wsel : 4'hF)});
      end
      check_output("wb_write", {31'h0, wb_write}, {31'h0, m_wb_write});
      check_output("wb_rd", {27'h0, wb_rd}, {27'h0, m_wb_rd});
      check_output("wb_data", wb_data, m_wb_data);
      check_output("misalign", {31'h0, misalign}, {31'h0, m_mis});
      check_output("bus_err", {31'h0, bus_err}, {31'h0, m_err});
    end
    if (!reset_n) begin
      model_ok = 1'b1;
      {m_valid, m_load, m_store, m_rw, m_wb_write, m_mis, m_err} = '0;
      m_rd = '0; m_f3 = '0; m_addr = '0; m_wdata = '0; m_wsel = '0;
      m_wait = 0; m_wb_rd = '0; m_wb_data = '0;
    end else begin
      e_bad  = m_valid && e_mem && e_mis;
      e_done = m_valid && (!e_mem || e_mis || (e_req && (dbus_ack || e_timeout)));
      e_wb   = e_done && !e_bad && !e_timeout && m_rw && (m_rd != 0) && !m_store;
      m_mis      = e_bad;
      m_err      = e_timeout;
      m_wb_write = e_wb;
      if (e_wb) begin
        m_wb_rd   = m_rd;
        m_wb_data = m_load ? load_value(m_f3, m_addr, dbus_rdata) : m_addr;
      end
      if (e_stall) begin
        m_wait = m_wait + 1;
      end else begin
        m_wait  = 0;
        m_valid = 1'b1;
        m_load  = load;  m_store = store; m_rw = reg_write; m_rd = rd;
        m_f3    = funct3; m_addr = alu_result; m_wdata = wdata; m_wsel = wsel;
      end
    end
  end

  initial begin : driver
    int  cnt;
    bit  released;
    int  kind;
    logic [31:0] a;
    reset_n    = 1'b0;
    dbus_ack   = 1'b0;
    dbus_rdata = 32'h0;
    bubble();
    step();
    step();
    sample();
    check_output("rst_stall", {31'h0, stall}, 32'h0);
    check_output("rst_req", {31'h0, dbus_req}, 32'h0);
    check_output("rst_addr", dbus_addr, 32'h0);
    check_output("rst_wb_write", {31'h0, wb_write}, 32'h0);
    check_output("rst_wb_data", wb_data, 32'h0);

    // ALU op writes back one edge after its stage cycle
    step();
    reset_n = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b1, 5'd5, 3'd0, 32'h1234_5678, 32'h0, 4'h0);
    step();
    bubble();
    sample();
    check_output("alu_stall", {31'h0, stall}, 32'h0);
    step();
    sample();
    check_output("alu_wb_write", {31'h0, wb_write}, 32'h1);
    check_output("alu_wb_rd", {27'h0, wb_rd}, 32'd5);
    check_output("alu_wb_data", wb_data, 32'h1234_5678);

    // LB 0x103 acked on the fourth request cycle
    step();
    apply_stimulus(1'b1, 1'b0, 1'b1, 5'd7, 3'b000, 32'h0000_0103, 32'h0, 4'h0);
    step();
    bubble();
    for (int i = 0; i < 3; i++) begin
      sample();
      check_output("lb_stall", {31'h0, stall}, 32'h1);
      check_output("lb_addr", dbus_addr, 32'h0000_0100);
      step();
    end
    dbus_ack   = 1'b1;
    dbus_rdata = 32'h80AA_BBCC;
    sample();
    check_output("lb_ack_stall", {31'h0, stall}, 32'h0);
    step();
    dbus_ack = 1'b0;
    sample();
    check_output("lb_wb_write", {31'h0, wb_write}, 32'h1);
    check_output("lb_wb_data", wb_data, 32'hFFFF_FF80);

    // SH with zero-wait ack
    step();
    apply_stimulus(1'b0, 1'b1, 1'b0, 5'd0, 3'b001, 32'h0000_0202, 32'hBEEF_BEEF, 4'b1100);
    step();
    bubble();
    dbus_ack = 1'b1;
    sample();
    check_output("sh_req", {31'h0, dbus_req}, 32'h1);
    check_output("sh_we", {31'h0, dbus_we}, 32'h1);
    check_output("sh_stall", {31'h0, stall}, 32'h0);
    check_output("sh_sel", {28'h0, dbus_sel}, 32'hC);
    step();
    dbus_ack = 1'b0;
    sample();
    check_output("sh_req_drop", {31'h0, dbus_req}, 32'h0);
    check_output("sh_no_wb", {31'h0, wb_write}, 32'h0);

    // Misaligned LW, followed immediately by an ALU op
    step();
    apply_stimulus(1'b1, 1'b0, 1'b1, 5'd3, 3'b010, 32'h0000_0101, 32'h0, 4'h0);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b1, 5'd9, 3'd0, 32'hCAFE_0009, 32'h0, 4'h0);
    sample();
    check_output("mis_req", {31'h0, dbus_req}, 32'h0);
    check_output("mis_stall", {31'h0, stall}, 32'h0);
    step();
    bubble();
    sample();
    check_output("mis_pulse", {31'h0, misalign}, 32'h1);
    check_output("mis_no_wb", {31'h0, wb_write}, 32'h0);
    step();
    sample();
    check_output("mis_next_wb_rd", {27'h0, wb_rd}, 32'd9);
    check_output("mis_next_wb_data", wb_data, 32'hCAFE_0009);

    // LHU never acked: timeout abort
    step();
    apply_stimulus(1'b1, 1'b0, 1'b1, 5'd4, 3'b101, 32'h0000_0010, 32'h0, 4'h0);
    step();
    bubble();
    cnt = 0;
    released = 1'b0;
    for (int i = 0; i < T + 4 && !released; i++) begin
      sample();
      if (dbus_req) cnt++;
      if (!stall) released = 1'b1;
      else step();
    end
    check_output("to_released", {31'h0, released}, 32'h1);
    check_output("to_req_cycles", cnt, T);
    step();
    sample();
    check_output("to_bus_err", {31'h0, bus_err}, 32'h1);
    check_output("to_no_wb", {31'h0, wb_write}, 32'h0);

    // Reset during BUS, late ack, then a back-to-back LW pair
    step();
    apply_stimulus(1'b1, 1'b0, 1'b1, 5'd6, 3'b010, 32'h0000_0020, 32'h0, 4'h0);
    step();
    bubble();
    sample();
    check_output("rb_req", {31'h0, dbus_req}, 32'h1);
    step();
    reset_n = 1'b0;
    step();
    reset_n    = 1'b1;
    dbus_ack   = 1'b1;
    dbus_rdata = 32'hDEAD_BEEF;
    apply_stimulus(1'b1, 1'b0, 1'b1, 5'd10, 3'b010, 32'h0000_0040, 32'h0, 4'h0);
    sample();
    check_output("rb_req_low", {31'h0, dbus_req}, 32'h0);
    check_output("rb_wb_data", wb_data, 32'h0);
    check_output("rb_wb_rd", {27'h0, wb_rd}, 32'h0);
    step();
    dbus_rdata = 32'h1111_2222;
    apply_stimulus(1'b1, 1'b0, 1'b1, 5'd11, 3'b010, 32'h0000_0044, 32'h0, 4'h0);
    sample();
    check_output("rb_late_no_wb", {31'h0, wb_write}, 32'h0);
    check_output("lw1_stall", {31'h0, stall}, 32'h0);
    step();
    dbus_rdata = 32'h3333_4444;
    bubble();
    sample();
    check_output("lw1_wb_rd", {27'h0, wb_rd}, 32'd10);
    check_output("lw1_wb_data", wb_data, 32'h1111_2222);
    step();
    dbus_ack = 1'b0;
    sample();
    check_output("lw2_wb_rd", {27'h0, wb_rd}, 32'd11);
    check_output("lw2_wb_data", wb_data, 32'h3333_4444);

    // Randomized run; the model process checks every cycle
    for (int n = 0; n < 3000; n++) begin
      step();
      reset_n    = ($urandom_range(0, 199) != 0);
      dbus_ack   = ($urandom_range(0, 99) < 30);
      dbus_rdata = $urandom();
      a = $urandom() & 32'h0000_0FFF;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      kind = $urandom_range(0, 9);
      if (kind <= 2) begin
        apply_stimulus(1'b0, 1'b0, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), 3'd0,
                       $urandom(), $urandom(), 4'($urandom_range(0, 15)));
      end else if (kind <= 5) begin
        case ($urandom_range(0, 4))
          0:       funct3 = 3'b000;
          1:       funct3 = 3'b001;
          2:       funct3 = 3'b010;
          3:       funct3 = 3'b100;
          default: funct3 = 3'b101;
        endcase
        apply_stimulus(1'b1, 1'b0, ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 31)), funct3,
                       a, $urandom(), 4'($urandom_range(0, 15)));
      end else if (kind <= 7) begin
        apply_stimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                       3'($urandom_range(0, 2)), a, $urandom(), 4'($urandom_range(1, 15)));
      end else begin
        bubble();
      end
    end
    step();
    reset_n  = 1'b1;
    dbus_ack = 1'b1;
    bubble();
    step();
    step();
    dbus_ack = 1'b0;
    sample();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
